decode_issue_queue: RTL and testbench
=====================================

# decode_issue_queue

Decoupling queue between the decode stage and `issue_stage`. It buffers up to `DEPTH` decoded `scoreboard_entry_t` instructions, each with its control-flow flag, and presents them in order to the issue stage's `decoded_instr_*` valid/ack handshake. It absorbs issue-side back-pressure (scoreboard full, operand hazards) without stalling the decoder. It also counts queued control-flow instructions so the frontend can throttle speculation.

## Interface
- `CVA6Cfg`, `config_pkg::cva6_cfg_empty`: core configuration; passed through, not interpreted.
- `DEPTH`, 4: number of entries; power of two, ≥2.
- `clk_i` input 1: clock.
- `rst_i` input 1: reset, synchronous, active-high.
- `flush_i` input 1: discard all queued entries (mispredict or exception).
- `decoded_instr_i` input `scoreboard_entry_t`: entry from decode.
- `decoded_instr_valid_i` input 1: `decoded_instr_i` is valid.
- `is_ctrl_flow_i` input 1: the entry is a branch or jump.
- `decoded_instr_ack_o` output 1: entry accepted this cycle.
- `decoded_instr_o` output `scoreboard_entry_t`: head entry to `issue_stage`.
- `decoded_instr_valid_o` output 1: head valid.
- `is_ctrl_flow_o` output 1: head control-flow flag.
- `decoded_instr_ack_i` input 1: `issue_stage` consumed the head this cycle.
- `occupancy_o` output `$clog2(DEPTH+1)`: number of stored entries.
- `cf_count_o` output `$clog2(DEPTH+1)`: number of stored control-flow entries.
- `full_o` output 1: `occupancy_o == DEPTH`.

## Operation
- Storage is a circular register array.
  - Read pointer and write pointer are each `$clog2(DEPTH)` bits and wrap naturally at `DEPTH-1 → 0`.
  - A separate occupancy counter distinguishes full from empty.
- Push: `decoded_instr_ack_o = decoded_instr_valid_i & ~full_o & ~flush_i`. The entry and its flag are written at the write pointer, and the pointer increments.
- Push is not allowed when full, even if a pop happens in the same cycle. This keeps `decoded_instr_ack_o` free of any combinational path from `decoded_instr_ack_i`.
- Pop: happens when `decoded_instr_valid_o & decoded_instr_ack_i`. The read pointer increments.
  - Ack with valid low is ignored.
  - Ack while `flush_i` is high is ignored.
- Output: `decoded_instr_valid_o = (occupancy_o != 0) & ~flush_i`.
  - Head data is always driven from the read pointer.
  - Head data is don't-care when valid is low.
- Push and pop in the same cycle: occupancy is unchanged and both pointers advance.
- `cf_count_o` rules, per cycle:
  - +1 on a push with `is_ctrl_flow_i=1`.
  - −1 on a pop with head flag 1.
  - Both in the same cycle: unchanged.
  - Never underflows or overflows; an assertion guards this.
- Flush: in the cycle `flush_i` is high, valid and ack outputs are 0. On the next edge, pointers, occupancy and `cf_count_o` are 0. Flush overrides push and pop.
- Reset (`rst_i` at an edge) has the same effect as flush, including mid-operation.
  - Storage contents are not reset.
  - All outputs read as valid/ack 0 and counts 0 after reset.

## Timing
- Latency without bypass: an entry pushed at edge N appears on `decoded_instr_valid_o` in the cycle after N, i.e. 1 cycle.
- Throughput: 1 push and 1 pop per cycle, sustained while 0 < occupancy < `DEPTH`.
- Full throughput at full occupancy is not sustained. One bubble cycle is accepted there by design.
- `decoded_instr_ack_o`, `decoded_instr_valid_o`, `occupancy_o`, `cf_count_o` and `full_o` are functions of registered state plus `flush_i`/`decoded_instr_valid_i`. None of them depends on `decoded_instr_ack_i` (in the non-bypass build).

## Configuration
- `DIQ_BYPASS_EN` defined:
  - When the queue is empty and `~flush_i`, the outputs are driven combinationally from the inputs: `decoded_instr_valid_o = decoded_instr_valid_i`, `decoded_instr_o = decoded_instr_i`, `is_ctrl_flow_o = is_ctrl_flow_i`.
  - If `decoded_instr_ack_i` is high in that cycle, the entry is not written. Pointers, occupancy and `cf_count_o` are unchanged; latency is 0.
  - Otherwise the entry is pushed normally.
  - `decoded_instr_ack_o` is unchanged: it never depends on `decoded_instr_ack_i`.
- Undefined: no bypass; latency is always 1 cycle.

## Structure
- `ariane_pkg` gains `diq_entry_t` = {`scoreboard_entry_t sbe`; `logic is_ctrl_flow`}, the stored word.
- No new constants are needed; `DEPTH` stays a module parameter.
- Single module with no sub-module. The storage array, pointer logic and counters are small enough to stay flat.

## Test plan
- Fill and drain: `DEPTH`=4, push 4 entries with PCs 0x100, 0x104, 0x108, 0x10C and ack held low.
  - `full_o`=1 and the 5th push gets ack 0.
  - Drain with ack held high: entries come out in PC order at 1 per cycle, then `occupancy_o`=0.
- Streaming: valid_i and ack_i continuously high for 20 cycles.
  - Without bypass: first output 1 cycle after the first push, then 1 entry per cycle, with no loss or duplication.
  - `occupancy_o` stays at 1.
- Control-flow count: push branch, ALU, jump, giving `cf_count_o`=2.
  - Pop the branch while pushing a branch in the same cycle: stays 2.
  - Pop the remaining entries: 0.
- Flush mid-stream: occupancy 3 with `cf_count_o` 1; assert `flush_i` with valid_i and ack_i also high.
  - Same cycle: ack_o=0 and valid_o=0.
  - Next cycle: occupancy and `cf_count_o` are 0, and the next push appears with its PC first.
- Pointer wrap: 3×`DEPTH`+1 push/pop pairs at varying occupancy. The scoreboard model matches every popped entry across pointer wrap.
- Bypass build: empty queue, valid_i and ack_i both high with PC 0x200.
  - `decoded_instr_o.pc`=0x200 in the same cycle, and occupancy stays 0.
  - Same stimulus with ack_i=0: entry stored, occupancy becomes 1.

Source files
------------

// File: rtl/decode_issue_queue_pkg.sv
// Types shared by the decode/issue decoupling queue: the decoded entry, the stored word
// and the pass-through core configuration.
package decode_issue_queue_pkg;

  typedef struct packed {
    logic [7:0] xlen;
    logic       rvc;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '0;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  fu;
    logic [7:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } scoreboard_entry_t;

  typedef struct packed {
    scoreboard_entry_t sbe;
    logic              is_ctrl_flow;
  } diq_entry_t;

endpackage

// File: rtl/decode_issue_queue.sv
// In-order queue between decode and issue with a control-flow entry counter.
// Optional same-cycle bypass on an empty queue when DIQ_BYPASS_EN is defined.
module decode_issue_queue
  import decode_issue_queue_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg = cva6_cfg_empty,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  scoreboard_entry_t          decoded_instr_i,
  input  logic                       decoded_instr_valid_i,
  input  logic                       is_ctrl_flow_i,
  output logic                       decoded_instr_ack_o,
  output scoreboard_entry_t          decoded_instr_o,
  output logic                       decoded_instr_valid_o,
  output logic                       is_ctrl_flow_o,
  input  logic                       decoded_instr_ack_i,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
  output logic [$clog2(DEPTH+1)-1:0] cf_count_o,
  output logic                       full_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  diq_entry_t      mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] occ_q, occ_d, cf_q, cf_d;
  logic            empty, push, pop, bypass, head_cf, cf_inc, cf_dec;
  logic            unused_cfg;

  assign unused_cfg = ^CVA6Cfg;

  assign empty               = (occ_q == '0);
  assign full_o              = (occ_q == CntW'(DEPTH));
  assign decoded_instr_ack_o = decoded_instr_valid_i & ~full_o & ~flush_i;
  assign head_cf             = mem_q[rd_ptr_q].is_ctrl_flow;
  assign occupancy_o         = occ_q;
  assign cf_count_o          = cf_q;

`ifdef DIQ_BYPASS_EN
  // An entry consumed straight through on an empty queue is never stored.
  assign bypass = empty & ~flush_i & decoded_instr_valid_i & decoded_instr_ack_i;

  always_comb begin
    if (empty & ~flush_i) begin
      decoded_instr_valid_o = decoded_instr_valid_i;
      decoded_instr_o       = decoded_instr_i;
      is_ctrl_flow_o        = is_ctrl_flow_i;
    end else begin
      decoded_instr_valid_o = ~empty & ~flush_i;
      decoded_instr_o       = mem_q[rd_ptr_q].sbe;
      is_ctrl_flow_o        = head_cf;
    end
  end
`else
  assign bypass                = 1'b0;
  assign decoded_instr_valid_o = ~empty & ~flush_i;
  assign decoded_instr_o       = mem_q[rd_ptr_q].sbe;
  assign is_ctrl_flow_o        = head_cf;
`endif

  assign push   = decoded_instr_ack_o & ~bypass;
  assign pop    = ~empty & ~flush_i & decoded_instr_ack_i;
  assign cf_inc = push & is_ctrl_flow_i;
  assign cf_dec = pop & head_cf;

  always_comb begin
    occ_d = occ_q;
    cf_d  = cf_q;
    if (push && !pop) begin
      occ_d = occ_q + CntW'(1);
    end else if (pop && !push) begin
      occ_d = occ_q - CntW'(1);
    end
    if (cf_inc && !cf_dec) begin
      cf_d = cf_q + CntW'(1);
    end else if (cf_dec && !cf_inc) begin
      cf_d = cf_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      cf_q     <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      occ_q <= occ_d;
      cf_q  <= cf_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{sbe: decoded_instr_i, is_ctrl_flow: is_ctrl_flow_i};
    end
  end

  cf_bounded: assert property (@(posedge clk_i) disable iff (rst_i) cf_q <= occ_q);
  cf_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(cf_dec && !cf_inc && cf_q == '0));

endmodule

// File: tb/tb_decode_issue_queue.sv
// Scoreboard bench for decode_issue_queue: directed stimulus, monitor checks head entries.
module tb_decode_issue_queue;
  import decode_issue_queue_pkg::*;

  localparam int unsigned Depth = 4;
`ifdef DIQ_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              flush_i;
  scoreboard_entry_t decoded_instr_i;
  logic              decoded_instr_valid_i;
  logic              is_ctrl_flow_i;
  logic              decoded_instr_ack_o;
  scoreboard_entry_t decoded_instr_o;
  logic              decoded_instr_valid_o;
  logic              is_ctrl_flow_o;
  logic              decoded_instr_ack_i;
  logic [2:0]        occupancy_o;
  logic [2:0]        cf_count_o;
  logic              full_o;

  int checks = 0;
  int failures = 0;
  int m_occ = 0;
  int m_cf = 0;
  diq_entry_t sb[$];

  always #5 clk_i = ~clk_i;

  decode_issue_queue #(
    .CVA6Cfg (cva6_cfg_empty),
    .DEPTH   (Depth)
  ) dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .flush_i               (flush_i),
    .decoded_instr_i       (decoded_instr_i),
    .decoded_instr_valid_i (decoded_instr_valid_i),
    .is_ctrl_flow_i        (is_ctrl_flow_i),
    .decoded_instr_ack_o   (decoded_instr_ack_o),
    .decoded_instr_o       (decoded_instr_o),
    .decoded_instr_valid_o (decoded_instr_valid_o),
    .is_ctrl_flow_o        (is_ctrl_flow_o),
    .decoded_instr_ack_i   (decoded_instr_ack_i),
    .occupancy_o           (occupancy_o),
    .cf_count_o            (cf_count_o),
    .full_o                (full_o)
  );

  function automatic scoreboard_entry_t mk(input logic [31:0] pc);
    scoreboard_entry_t e;
    e.pc  = pc;
    e.fu  = pc[5:2];
    e.op  = pc[11:4] ^ 8'h5a;
    e.rs1 = pc[6:2];
    e.rs2 = ~pc[6:2];
    e.rd  = pc[8:4];
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle, checks handshake/counters against the model, then updates it.
  task automatic drive(input bit v, input bit cf, input logic [31:0] pc, input bit ack,
                       input bit fl);
    bit exp_ack, exp_valid, byp, do_push, do_pop, hcf;
    @(posedge clk_i);
    #1;
    decoded_instr_valid_i = v;
    is_ctrl_flow_i        = cf;
    decoded_instr_i       = mk(pc);
    decoded_instr_ack_i   = ack;
    flush_i               = fl;
    @(negedge clk_i);
    exp_ack   = v && !fl && (m_occ != Depth);
    byp       = Byp && (m_occ == 0) && !fl && v && ack;
    exp_valid = !fl && ((m_occ != 0) || (Byp && v));
    chk("ack_o", decoded_instr_ack_o, exp_ack);
    chk("valid_o", decoded_instr_valid_o, exp_valid);
    chk("occupancy", occupancy_o, m_occ);
    chk("cf_count", cf_count_o, m_cf);
    chk("full", full_o, m_occ == Depth);
    if (fl) begin
      sb.delete();
      m_occ = 0;
      m_cf  = 0;
    end else begin
      do_pop  = (m_occ != 0) && ack && (sb.size() > 0);
      hcf     = do_pop ? sb[0].is_ctrl_flow : 1'b0;
      do_push = exp_ack && !byp;
      if (exp_ack) sb.push_back('{sbe: mk(pc), is_ctrl_flow: cf});
      m_occ = m_occ + int'(do_push) - int'(do_pop);
      m_cf  = m_cf + int'(do_push && cf) - int'(hcf);
    end
  endtask

  task automatic do_reset();
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    decoded_instr_valid_i = 1'b0;
    decoded_instr_ack_i   = 1'b0;
    flush_i               = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    sb.delete();
    m_occ = 0;
    m_cf  = 0;
    @(negedge clk_i);
    chk("reset_occ", occupancy_o, 0);
    chk("reset_cf", cf_count_o, 0);
    chk("reset_valid", decoded_instr_valid_o, 0);
    chk("reset_full", full_o, 0);
  endtask

  // Monitor: runs just after the driver's sampling point on every cycle.
  always @(negedge clk_i) begin
    #1;
    if (decoded_instr_valid_o && decoded_instr_ack_i && !rst_i) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pop actual_pc=%0h required=none", decoded_instr_o.pc);
      end else begin
        if (decoded_instr_o !== sb[0].sbe || is_ctrl_flow_o !== sb[0].is_ctrl_flow) begin
          failures++;
          $display("FAIL head_entry actual_pc=%0h cf=%0b required_pc=%0h cf=%0b",
                   decoded_instr_o.pc, is_ctrl_flow_o, sb[0].sbe.pc, sb[0].is_ctrl_flow);
        end
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    rst_i = 1'b1;
    flush_i = 1'b0;
    decoded_instr_valid_i = 1'b0;
    decoded_instr_ack_i = 1'b0;
    is_ctrl_flow_i = 1'b0;
    decoded_instr_i = mk(32'h0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("init_occ", occupancy_o, 0);
    chk("init_cf", cf_count_o, 0);
    chk("init_valid", decoded_instr_valid_o, 0);
    chk("init_ack", decoded_instr_ack_o, 0);

    // Fill and drain
    for (int i = 0; i < 4; i++) drive(1, 0, 32'h100 + 32'(4 * i), 0, 0);
    drive(1, 0, 32'h110, 0, 0);
    chk("fill_full", full_o, 1);
    chk("fill_5th_ack", decoded_instr_ack_o, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 32'h0, 1, 0);
    drive(0, 0, 32'h0, 0, 0);
    chk("drain_occ", occupancy_o, 0);

    // Streaming
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 32'h300 + 32'(4 * i), 1, 0);
      if (i == 10) chk("stream_occ", occupancy_o, Byp ? 0 : 1);
    end
    drive(0, 0, 32'h0, 1, 0);
    drive(0, 0, 32'h0, 0, 0);
    chk("stream_empty", occupancy_o, 0);

    // Control-flow count
    drive(1, 1, 32'h400, 0, 0);
    drive(1, 0, 32'h404, 0, 0);
    drive(1, 1, 32'h408, 0, 0);
    drive(1, 1, 32'h40c, 1, 0);
    chk("cf_two", cf_count_o, 2);
    drive(0, 0, 32'h0, 1, 0);
    chk("cf_after_swap", cf_count_o, 2);
    for (int i = 0; i < 3; i++) drive(0, 0, 32'h0, 1, 0);
    drive(0, 0, 32'h0, 0, 0);
    chk("cf_zero", cf_count_o, 0);

    // Flush mid-stream
    drive(1, 1, 32'h500, 0, 0);
    drive(1, 0, 32'h504, 0, 0);
    drive(1, 0, 32'h508, 0, 0);
    drive(1, 0, 32'h50c, 1, 1);
    chk("flush_ack", decoded_instr_ack_o, 0);
    chk("flush_valid", decoded_instr_valid_o, 0);
    drive(1, 0, 32'h510, 0, 0);
    chk("flush_occ", occupancy_o, 0);
    chk("flush_cf", cf_count_o, 0);
    drive(0, 0, 32'h0, 1, 0);
    drive(0, 0, 32'h0, 0, 0);

    // Pointer wrap at varying occupancy
    for (int i = 0; i < 3 * Depth + 1; i++) begin
      drive(1, i[0], 32'h600 + 32'(4 * i), (i % 4) != 0, 0);
    end
    for (int i = 0; i < 8 && m_occ > 0; i++) drive(0, 0, 32'h0, 1, 0);
    drive(0, 0, 32'h0, 0, 0);
    chk("wrap_empty", occupancy_o, 0);

    // Reset mid-operation
    drive(1, 1, 32'h700, 0, 0);
    drive(1, 0, 32'h704, 0, 0);
    do_reset();
    drive(1, 0, 32'h708, 0, 0);
    drive(0, 0, 32'h0, 1, 0);
    drive(0, 0, 32'h0, 0, 0);

`ifdef DIQ_BYPASS_EN
    drive(1, 0, 32'h200, 1, 0);
    chk("byp_pc", decoded_instr_o.pc, 32'h200);
    drive(1, 0, 32'h204, 0, 0);
    chk("byp_occ_zero", occupancy_o, 0);
    drive(0, 0, 32'h0, 0, 0);
    chk("byp_store", occupancy_o, 1);
    drive(0, 0, 32'h0, 1, 0);
    drive(0, 0, 32'h0, 0, 0);
`endif

    @(negedge clk_i);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
